// File: rtl/calc_operand_seq.sv
// Serial operand/opcode collector and executor for the binary calculator.
// Define CALC_MUL_EN to turn opcode 11 into MUL; otherwise it is OR.
module calc_operand_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Active,
  input  logic             Mode,
  input  logic             ValidCmd,
  input  logic             InputKey,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             OutValid,
  output logic             Busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPA,
    S_OPB,
    S_OPC,
    S_EXEC
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [1:0]       op_sr;
  logic             mode_lat;

  logic             collecting;
  logic             accept;
  logic             abort;
  logic             first_bit;
  logic             last_bit;
  logic             exec;
  logic             bit_mode;
  logic [WIDTH:0]   alu_out;

  // Returns {carry, result}.
  function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [1:0]       op);
    logic [WIDTH:0] r;
`ifdef CALC_MUL_EN
    logic [2*WIDTH-1:0] prod;
`endif
    r = '0;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a < b), a - b};
      2'b10:   r = {1'b0, a & b};
      default: begin
`ifdef CALC_MUL_EN
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        r    = {|prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0]};
`else
        r    = {1'b0, a | b};
`endif
      end
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] sr,
                                                  input logic             lsb_first,
                                                  input logic             din);
    if (lsb_first) return {din, sr[WIDTH-1:1]};
    return {sr[WIDTH-2:0], din};
  endfunction

  function automatic logic [1:0] shift_op(input logic [1:0] sr,
                                          input logic       lsb_first,
                                          input logic       din);
    if (lsb_first) return {din, sr[1]};
    return {sr[0], din};
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Active) state_nxt = S_OPA;
      S_OPA: begin
        if (abort)         state_nxt = S_IDLE;
        else if (last_bit) state_nxt = S_OPB;
      end
      S_OPB: begin
        if (abort)         state_nxt = S_IDLE;
        else if (last_bit) state_nxt = S_OPC;
      end
      S_OPC: begin
        if (abort)         state_nxt = S_IDLE;
        else if (last_bit) state_nxt = S_EXEC;
      end
      S_EXEC:  state_nxt = Active ? S_OPA : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    collecting = (state == S_OPA) || (state == S_OPB) || (state == S_OPC);
    accept     = collecting && Active && ValidCmd;
    abort      = collecting && !Active;
    first_bit  = accept && (state == S_OPA) && (cnt == '0);
    last_bit   = accept && (((state != S_OPC) && (cnt == CNT_W'(WIDTH - 1))) ||
                            ((state == S_OPC) && (cnt == CNT_W'(1))));
    exec       = (state == S_EXEC);
    // The first bit of a frame uses the live Mode, since the latch loads on that same edge.
    bit_mode   = first_bit ? Mode : mode_lat;
  end

  assign alu_out = alu(a_sr, b_sr, op_sr);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      op_sr    <= '0;
      mode_lat <= 1'b0;
    end else begin
      if (!collecting || abort || last_bit) cnt <= '0;
      else if (accept)                      cnt <= cnt + CNT_W'(1);
      if (first_bit) mode_lat <= Mode;
      if (accept && (state == S_OPA)) a_sr  <= shift_word(a_sr, bit_mode, InputKey);
      if (accept && (state == S_OPB)) b_sr  <= shift_word(b_sr, bit_mode, InputKey);
      if (accept && (state == S_OPC)) op_sr <= shift_op(op_sr, bit_mode, InputKey);
    end
  end

  // Execute stage: results register here and hold until the next frame completes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Result   <= '0;
      Carry    <= 1'b0;
      Zero     <= 1'b0;
      OutValid <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      OutValid <= exec;
      if (exec) begin
        Result <= alu_out[WIDTH-1:0];
        Carry  <= alu_out[WIDTH];
        Zero   <= (alu_out[WIDTH-1:0] == '0);
      end
      if (first_bit)          Busy <= 1'b1;
      else if (exec || abort) Busy <= 1'b0;
    end
  end

endmodule

// File: doc/calc_operand_seq.md
Name: calc_operand_seq

Overview:
Downstream stage of the key-unlock decoder in the binary calculator. Once the decoder asserts Active, this block collects a serial frame on the same InputKey/ValidCmd strobe pair: operand A, operand B, then a 2-bit opcode. It executes the operation and presents a registered result with flags and a one-cycle OutValid pulse. It returns to collecting the next frame automatically.

Parameters:
WIDTH, 8, operand and result width in bits (min 2).

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset).
Active  input  1  unlock flag from key decoder; block idles while 0.
Mode  input  1  bit-order select from key decoder, sampled at first bit of each frame.
ValidCmd  input  1  bit strobe; InputKey accepted on rising Clk when 1.
InputKey  input  1  serial data bit.
Result  output  WIDTH  registered operation result.
Carry  output  1  carry-out (ADD), borrow (SUB), overflow (MUL), else 0.
Zero  output  1  1 when Result == 0.
OutValid  output  1  one-cycle pulse: Result/Carry/Zero updated.
Busy  output  1  1 from first accepted bit until OutValid or abort.

Behaviour:
- Reset (Reset=0, async): state IDLE; Result=0, Carry=0, Zero=0, OutValid=0, Busy=0; shift registers and bit counter cleared.
- States: IDLE, OPA, OPB, OPC, EXEC.
- IDLE: Active=1 -> OPA at next edge; ValidCmd ignored in IDLE.
- Bit acceptance: only in OPA/OPB/OPC with ValidCmd=1 and Active=1.
- Bit count per field: OPA WIDTH bits, OPB WIDTH bits, OPC 2 bits. Counter resets at each field change.
- Mode latch: Mode is latched on the first accepted bit of OPA and held for the whole frame; Mode changes mid-frame have no effect.
  - Latched Mode=0: MSB-first for A, B and opcode; shift left, insert at LSB.
  - Latched Mode=1: LSB-first; shift right, insert at MSB.
- Busy rises on the same edge as the first accepted OPA bit.
- Last OPC bit edge -> EXEC. ValidCmd during EXEC is ignored and the bit is dropped.
- EXEC edge:
  - Result, Carry and Zero are registered.
  - OutValid=1 for exactly one cycle; Busy=0.
  - State -> OPA (or IDLE if Active=0).
  - Latency: result visible one clock after the final opcode bit is accepted.
- Opcodes:
  - 00 ADD: {Carry,Result} = A+B.
  - 01 SUB: Result = A-B mod 2^WIDTH; Carry=1 iff A<B.
  - 10 AND: Carry=0.
  - 11 OR: Carry=0 (see Optional Feature).
- Result/Carry/Zero hold their values until the next EXEC or reset. OutValid=0 at all other times.
- Active falls in OPA/OPB/OPC (abort):
  - Next edge -> IDLE; partial frame discarded; counter cleared; Busy=0.
  - No OutValid; Result is unchanged.
- Active falls in EXEC: the result still completes and OutValid pulses; then IDLE.
- Reset asserted mid-frame or during EXEC: immediate clear; no OutValid is produced.
- Reset release: first edge with Reset=1 evaluates from IDLE.

Optional Feature:
CALC_MUL_EN
- Defined: opcode 11 = MUL. Result = low WIDTH bits of A*B; Carry=1 iff the upper WIDTH bits are nonzero. Result still registered in the single EXEC cycle (combinational multiplier).
- Undefined: opcode 11 = OR, and no multiplier is instantiated.

Test Plan:
1. WIDTH=8, Active=1, Mode=0; send A=0x35, B=0x0A, op 00 MSB-first -> Result=0x3F, Carry=0, Zero=0; OutValid high exactly one cycle, one clock after the last opcode bit; Busy falls with it.
2. Mode=0, A=0x05, B=0x07, op 01 -> Result=0xFE, Carry=1. Then A=0xFF, B=0x01, op 00 -> Result=0x00, Carry=1, Zero=1.
3. Mode=1 at the first bit, toggle Mode mid-frame; A bits 1,0,0,0,0,0,0,0; B=0x02 LSB-first; op bits 0,1 (opcode 10 AND) -> A=0x01, Result=0x00, Zero=1; the Mode toggle has no effect.
4. Drop Active after 5 OPA bits -> IDLE, Busy=0, no OutValid, Result unchanged. Re-assert Active and send a full frame (A=0x10, B=0x01, op 00) -> Result=0x11.
5. Pulse Reset=0 asynchronously mid-OPB -> all outputs 0 immediately, no OutValid. ValidCmd held high during EXEC -> extra bit dropped; next frame decodes correctly.
6. A=0x10, B=0x11, op 11: with CALC_MUL_EN -> Result=0x10, Carry=1; without -> Result=0x11, Carry=0.
